// File: rtl/isu_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
package isu_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        DATA  = 3'd3,
        FLUSH = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_e;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/isu_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface isu_loader_if #(
    parameter int BYTE_W  = 8,
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 32
);
    logic               in_valid;
    logic [BYTE_W-1:0]  in_data;
    logic               in_ready;
    logic               mem_we;
    logic [A_WIDTH-1:0] mem_addr;
    logic [D_WIDTH-1:0] mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/isu_loader_byte_packer.sv
// Collects stream bytes little-endian into a word; flags the cycle the last byte arrives.
module isu_loader_byte_packer
    import isu_loader_pkg::*;
#(
    parameter int BYTE_W  = 8,
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               accept_i,
    input  logic [BYTE_W-1:0]  byte_i,
    output logic [D_WIDTH-1:0] word_o,
    output logic               wordValid_o
);
    localparam int CNT_BITS = $clog2(BYTES_PER_WORD);

    logic [CNT_BITS-1:0]       byteCnt_q;
    logic [D_WIDTH-BYTE_W-1:0] pack_q;

    // The top byte is never stored: it goes straight from the stream into the word.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            byteCnt_q <= '0;
            pack_q    <= '0;
        end else if (accept_i) begin
            for (int b = 0; b < BYTES_PER_WORD - 1; b++) begin
                if (byteCnt_q == CNT_BITS'(b)) begin
                    pack_q[b*BYTE_W +: BYTE_W] <= byte_i;
                end
            end
            byteCnt_q <= byteCnt_q + 1'b1;
        end
    end

    assign wordValid_o = accept_i && (byteCnt_q == CNT_BITS'(BYTES_PER_WORD - 1));
    assign word_o      = {byte_i, pack_q};

endmodule

// File: rtl/isu_loader.sv
// Program loader: reads a counted byte image and writes it to instruction memory,
// holding the core in reset until the whole image has landed.
module isu_loader
    import isu_loader_pkg::*;
#(
    parameter int D_WIDTH     = 32,
    parameter int A_WIDTH     = 32,
    parameter int MEM_A_WIDTH = 8,
    parameter int BYTE_W      = 8,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    isu_loader_if.slave bus,
    output logic       cpu_rst_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);
    localparam logic [CNT_W:0] MAX_WORDS = (CNT_W + 1)'(2 ** MEM_A_WIDTH);

    state_e             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   wordIdx_q;
    logic [CNT_W-1:0]   lastIdx;
    logic [CNT_W-1:0]   hdrCount;
    logic               accept;
    logic               pkValid;
    logic [D_WIDTH-1:0] pkWord;

    assign bus.in_ready = (state_q inside {HDR0, HDR1, DATA});
    assign accept       = bus.in_valid && bus.in_ready;
    assign hdrCount     = {bus.in_data, count_q[BYTE_W-1:0]};
    assign lastIdx      = count_q - 1'b1;

    isu_loader_byte_packer #(
        .BYTE_W (BYTE_W),
        .D_WIDTH(D_WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (accept && (state_q == HDR1)),
        .accept_i   (accept && (state_q == DATA)),
        .byte_i     (bus.in_data),
        .word_o     (pkWord),
        .wordValid_o(pkValid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            count_q       <= '0;
            wordIdx_q     <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start_i) begin
                        state_q   <= HDR0;
                        wordIdx_q <= '0;
                    end
                end
                HDR0: begin
                    if (accept) begin
                        count_q[BYTE_W-1:0] <= bus.in_data;
                        state_q             <= HDR1;
                    end
                end
                HDR1: begin
                    // Size is validated up front so the write address can never wrap.
                    if (accept) begin
                        count_q[CNT_W-1:BYTE_W] <= bus.in_data;
                        wordIdx_q               <= '0;
                        if (hdrCount == '0) begin
                            state_q <= DONE;
                        end else if ({1'b0, hdrCount} > MAX_WORDS) begin
                            state_q <= ERR;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (pkValid) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_wdata <= pkWord;
                        bus.mem_addr  <= A_WIDTH'({wordIdx_q[MEM_A_WIDTH-1:0], 2'b00});
                        wordIdx_q     <= wordIdx_q + 1'b1;
                        if (wordIdx_q == lastIdx) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_rst_o = (state_q != DONE);
    assign busy_o    = (state_q inside {HDR0, HDR1, DATA, FLUSH});
    assign done_o    = (state_q == DONE);
    assign err_o     = (state_q == ERR);

endmodule

// File: tb/tb_isu_loader.sv
// Self-checking bench for isu_loader: fixed corner sequences plus a table of randomized loads.
module tb_isu_loader;

    logic clk = 1'b0;
    logic rst;
    logic start_i;
    logic cpu_rst_o, busy_o, done_o, err_o;

    isu_loader_if bus ();

    isu_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .bus      (bus.slave),
        .cpu_rst_o(cpu_rst_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    logic [63:0] gotQ[$];
    logic [63:0] expQ[$];

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) gotQ.push_back({bus.mem_addr, bus.mem_wdata});
    end

    typedef struct {
        int count;
        int gap;
        bit expDone;
        bit expErr;
        int expWrites;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int t = 0; t < 40 && !ok; t++) begin
            if (bus.in_ready === 1'b1) ok = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        if (!ok) checkOutput("byte_accept_timeout", 64'd0, 64'd1);
        repeat (gap) tick();
    endtask

    // Reference: word i lands at byte address 4*i, bytes little-endian.
    task automatic buildExpected(input int count, input logic [7:0] data[$]);
        expQ.delete();
        if (count >= 1 && count <= 256) begin
            for (int i = 0; i < count; i++) begin
                logic [31:0] w;
                w = {data[4*i+3], data[4*i+2], data[4*i+1], data[4*i]};
                expQ.push_back({32'(4 * i), w});
            end
        end
    endtask

    task automatic compareWrites(input string tag);
        checkOutput({tag, "_write_count"}, 64'(gotQ.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checkOutput($sformatf("%s_write%0d", tag, i), gotQ[i], expQ[i]);
        end
    endtask

    task automatic applyStimulus(input int count, input int gap, input logic [7:0] data[$]);
        int g;
        gotQ.delete();
        pulseStart();
        sendByte(count[7:0], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
        sendByte(count[15:8], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
        if (count >= 1 && count <= 256) begin
            for (int i = 0; i < 4 * count; i++) begin
                g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                sendByte(data[i], g);
            end
        end
        repeat (3) tick();
    endtask

    initial begin
        logic [7:0] basic[$];
        logic [7:0] rnd[$];
        logic [7:0] part[$];

        rst          = 1'b1;
        start_i      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) tick();

        checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("reset_mem_we",   64'(bus.mem_we),   64'd0);
        checkOutput("reset_addr",     64'(bus.mem_addr), 64'd0);
        checkOutput("reset_wdata",    64'(bus.mem_wdata), 64'd0);
        checkOutput("reset_cpu_rst",  64'(cpu_rst_o),    64'd1);
        checkOutput("reset_flags",    64'({busy_o, done_o, err_o}), 64'd0);
        rst = 1'b0;
        tick();

        // Basic load with cycle-exact FLUSH/DONE timing.
        basic = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        gotQ.delete();
        pulseStart();
        checkOutput("hdr0_busy_ready", 64'({busy_o, bus.in_ready, cpu_rst_o}), 64'b111);
        sendByte(8'h02, 0);
        sendByte(8'h00, 0);
        for (int i = 0; i < 8; i++) sendByte(basic[i], 0);
        checkOutput("flush_mem_we",  64'(bus.mem_we), 64'd1);
        checkOutput("flush_flags",   64'({busy_o, cpu_rst_o, done_o, bus.in_ready}), 64'b1100);
        checkOutput("flush_addr",    64'(bus.mem_addr), 64'h4);
        checkOutput("flush_wdata",   64'(bus.mem_wdata), 64'h00200593);
        tick();
        checkOutput("done_mem_we",   64'(bus.mem_we), 64'd0);
        checkOutput("done_flags",    64'({done_o, cpu_rst_o, busy_o, err_o}), 64'b1000);
        repeat (3) tick();
        buildExpected(2, basic);
        checkOutput("basic_w0", gotQ.size() > 0 ? gotQ[0] : 64'hx, {32'h0, 32'h00100513});
        checkOutput("basic_w1", gotQ.size() > 1 ? gotQ[1] : 64'hx, {32'h4, 32'h00200593});
        compareWrites("basic_model");

        // Gapped stream with the same image.
        applyStimulus(2, 3, basic);
        buildExpected(2, basic);
        compareWrites("gapped");
        checkOutput("gapped_done", 64'({done_o, cpu_rst_o}), 64'b10);

        // Table of randomized loads.
        vecs[0] = '{count: 0,   gap: 0,  expDone: 1'b1, expErr: 1'b0, expWrites: 0};
        vecs[1] = '{count: 1,   gap: 1,  expDone: 1'b1, expErr: 1'b0, expWrites: 1};
        vecs[2] = '{count: 3,   gap: -1, expDone: 1'b1, expErr: 1'b0, expWrites: 3};
        vecs[3] = '{count: 257, gap: 0,  expDone: 1'b0, expErr: 1'b1, expWrites: 0};
        vecs[4] = '{count: 5,   gap: 0,  expDone: 1'b1, expErr: 1'b0, expWrites: 5};
        vecs[5] = '{count: 256, gap: 0,  expDone: 1'b1, expErr: 1'b0, expWrites: 256};
        vecs[6] = '{count: 65535, gap: 0, expDone: 1'b0, expErr: 1'b1, expWrites: 0};
        for (int v = 0; v < 7; v++) begin
            rnd.delete();
            if (vecs[v].count <= 256) begin
                for (int i = 0; i < 4 * vecs[v].count; i++) rnd.push_back(8'($urandom));
            end
            applyStimulus(vecs[v].count, vecs[v].gap, rnd);
            buildExpected(vecs[v].count, rnd);
            checkOutput($sformatf("vec%0d_done", v), 64'(done_o), 64'(vecs[v].expDone));
            checkOutput($sformatf("vec%0d_err", v),  64'(err_o),  64'(vecs[v].expErr));
            checkOutput($sformatf("vec%0d_cpu_rst", v), 64'(cpu_rst_o), 64'(!vecs[v].expDone));
            checkOutput($sformatf("vec%0d_nwrites", v), 64'(gotQ.size()), 64'(vecs[v].expWrites));
            compareWrites($sformatf("vec%0d", v));
        end

        // Oversize header, then a restart enters HDR0.
        rnd.delete();
        applyStimulus(257, 0, rnd);
        checkOutput("oversize_flags", 64'({err_o, bus.in_ready, cpu_rst_o, busy_o}), 64'b1010);
        checkOutput("oversize_writes", 64'(gotQ.size()), 64'd0);
        pulseStart();
        checkOutput("restart_busy_ready", 64'({busy_o, bus.in_ready, err_o}), 64'b110);

        // Reset in the middle of the second word.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        part.delete();
        for (int i = 0; i < 8; i++) part.push_back(8'($urandom));
        gotQ.delete();
        pulseStart();
        sendByte(8'h02, 0);
        sendByte(8'h00, 0);
        for (int i = 0; i < 6; i++) sendByte(part[i], 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_flags", 64'({bus.in_ready, cpu_rst_o, busy_o, done_o}), 64'b0100);
        repeat (5) tick();
        buildExpected(1, part);
        compareWrites("midrst");

        // Reload from DONE with a stray start during DATA.
        rnd.delete();
        for (int i = 0; i < 4; i++) rnd.push_back(8'($urandom));
        applyStimulus(1, 0, rnd);
        checkOutput("reload_pre_done", 64'({done_o, cpu_rst_o}), 64'b10);
        part.delete();
        for (int i = 0; i < 4; i++) part.push_back(8'($urandom));
        gotQ.delete();
        pulseStart();
        checkOutput("reload_cpu_rst", 64'({cpu_rst_o, busy_o, done_o}), 64'b110);
        sendByte(8'h01, 0);
        sendByte(8'h00, 0);
        sendByte(part[0], 0);
        sendByte(part[1], 0);
        pulseStart();
        checkOutput("stray_start_state", 64'({busy_o, bus.in_ready, bus.mem_we}), 64'b110);
        sendByte(part[2], 0);
        sendByte(part[3], 0);
        repeat (3) tick();
        buildExpected(1, part);
        compareWrites("reload");
        checkOutput("reload_done", 64'({done_o, cpu_rst_o}), 64'b10);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
